ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  Sits between the PS/2 keyboard receiver and the seg/ALU consumers; takes raw scan-code bytes and emits key events.
//  Parses set-2 framing (E0 extended, F0 break), tracks shift/caps state and the currently held key, and counts presses.
//  Each event carries the code, make/break, extended flag and ASCII; a one-entry output buffer provides valid/ready backpressure.
// PARAMETERS
//  CNT_W        8        width of key_count; wraps modulo 2**CNT_W
//  TIMEOUT_CYC  1000000  idle cycles allowed in a prefix state before abandoning the sequence
// PORTS
//  clk            in   1      system clock
//  rst            in   1      reset, asynchronous, active-high
//  in_valid       in   1      scan byte available from keyboard receiver
//  in_data        in   8      scan byte
//  in_ready       out  1      byte accepted when in_valid&&in_ready at posedge
//  evt_valid      out  1      event buffer holds an event
//  evt_ready      in   1      consumer takes event when evt_valid&&evt_ready
//  evt_code       out  8      scan code of event
//  evt_break      out  1      1 = release, 0 = press
//  evt_ext        out  1      code was E0-prefixed
//  evt_repeat     out  1      make of code already held (typematic)
//  evt_ascii      out  8      ASCII of code under current shift^caps; 0x00 if unmapped/extended/break
//  key_down       out  1      a key is currently held
//  held_code      out  8      last pressed code still held; 0x00 when none
//  key_count      out  CNT_W  number of non-repeat make events
//  shift_on       out  1      left(12) or right(59) shift held
//  caps_on        out  1      caps-lock toggle state
//  timeout        out  1      one-cycle pulse when a prefix sequence is abandoned
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, timeout counter 0; in_ready=1 on the first cycle after rst deasserts. Reset mid-sequence discards the buffered event.
//  in_ready = !evt_valid || evt_ready (combinational); bytes arriving while in_ready=0 stay with the upstream receiver.
//  FSM states: IDLE, EXT, BRK, EXT_BRK. On each accepted byte:
//   IDLE:  E0->EXT; F0->BRK; AA,FA,EE,FE,E1,00,FF discarded; else make event ext=0.
//   EXT:   F0->EXT_BRK; E0 stays EXT; else make event ext=1 ->IDLE.
//   BRK:   F0 stays BRK; E0->EXT (restart); else break event ext=0 ->IDLE.
//   EXT_BRK: F0 stays; E0->EXT; else break event ext=1 ->IDLE.
//  Latency: the event is registered; evt_valid rises the cycle after the completing byte is accepted and stays until the handshake completes.
//  Simultaneous evt pop and new event in one cycle: buffer reloads with the new event, evt_valid stays 1.
//  Make: repeat = (key_down && code==held_code && ext==held_ext); if !repeat: held_code<=code, key_down<=1, key_count++ (wraps).
//   Non-ext 58 make, !repeat: caps_on toggles. Non-ext 12/59 make sets the corresponding shift bit.
//  Break: matches held code/ext -> key_down<=0, held_code<=00; other codes leave held state. Non-ext 12/59 break clears its shift bit.
//  State updates apply in the same cycle the event is loaded; evt_ascii uses shift/caps values before that update.
//  ASCII map: letters 'a'-'z', 'A'-'Z' when shift^caps; digits 0-9 (shifted symbols per US layout); space 29->20; enter 5A->0D.
//  Timeout: in any non-IDLE state the counter increments each cycle with no accepted byte; at TIMEOUT_CYC-1 -> IDLE, timeout pulses 1 cycle, counter clears. Counter clears on every accepted byte.
// STRUCTURE
//  Package ps2_pkg: state enum, prefix constants E0/F0, shift/caps/enter/space codes, discard-code list.
//  Sub-module scancode_to_ascii: combinational code+shift+caps -> ascii; everything else lives in this file.
// TESTING
//  1C -> event code=1C brk=0 ext=0 ascii=61, key_down=1, key_count=1; F0 1C -> brk=1, ascii=00, key_down=0.
//  12, 1C, F0 1C, F0 12 -> second event ascii=41; caps: 58, F0 58, 1C -> ascii=41, caps_on=1.
//  E0 75 -> ext=1, ascii=00; E0 F0 75 -> brk=1 ext=1, key_down=0; FA/AA bytes -> no events.
//  1C x3 -> three events, repeat=0,1,1, key_count=1; key_count preset near 2**CNT_W-1 via 256 distinct presses wraps to 0.
//  evt_ready=0, send 1C, 32 -> in_ready drops after 1C, 32 held upstream; raise evt_ready -> both events delivered in order.
//  E0, idle TIMEOUT_CYC cycles -> timeout pulse; next 1C gives ext=0. Assert rst mid E0 F0 -> all outputs 0.

Source files
------------

// File: rtl/ps2_key_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ps2_pkg
// Purpose  : Shared types and scan-code constants for the PS/2 key decoder.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Prefix-parsing states: which set-2 prefixes have been seen so far
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  localparam logic [7:0] c_pfx_ext = 8'hE0;
  localparam logic [7:0] c_pfx_brk = 8'hF0;
  localparam logic [7:0] c_lshift  = 8'h12;
  localparam logic [7:0] c_rshift  = 8'h59;
  localparam logic [7:0] c_caps    = 8'h58;
  localparam logic [7:0] c_enter   = 8'h5A;
  localparam logic [7:0] c_space   = 8'h29;

  // Keyboard status/ack bytes that never start a key sequence
  localparam int         c_num_discard = 7;
  localparam logic [c_num_discard*8-1:0] c_discard_list =
    {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hE1, 8'h00, 8'hFF};

  function automatic logic is_discard(input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < c_num_discard; i++) begin
      if (c_discard_list[i*8 +: 8] == code) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_key_decoder_scancode_to_ascii.sv
`default_nettype none
// ============================================================================
// Module   : scancode_to_ascii
// Purpose  : Combinational set-2 make code to US-layout ASCII translation.
// Revision : 1.0 - initial release
// ============================================================================
module scancode_to_ascii (
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);
  import ps2_pkg::*;

  logic [7:0] base;   // unshifted character, 0 if unmapped
  logic [7:0] alt;    // shifted symbol for digit keys, 0 otherwise
  logic       letter;

  // Look up the base character and, for digits, the shifted symbol
  always_comb begin
    base = 8'h00;
    alt  = 8'h00;
    case (code)
      8'h1C: base = 8'h61;  8'h32: base = 8'h62;  8'h21: base = 8'h63;
      8'h23: base = 8'h64;  8'h24: base = 8'h65;  8'h2B: base = 8'h66;
      8'h34: base = 8'h67;  8'h33: base = 8'h68;  8'h43: base = 8'h69;
      8'h3B: base = 8'h6A;  8'h42: base = 8'h6B;  8'h4B: base = 8'h6C;
      8'h3A: base = 8'h6D;  8'h31: base = 8'h6E;  8'h44: base = 8'h6F;
      8'h4D: base = 8'h70;  8'h15: base = 8'h71;  8'h2D: base = 8'h72;
      8'h1B: base = 8'h73;  8'h2C: base = 8'h74;  8'h3C: base = 8'h75;
      8'h2A: base = 8'h76;  8'h1D: base = 8'h77;  8'h22: base = 8'h78;
      8'h35: base = 8'h79;  8'h1A: base = 8'h7A;
      8'h45: begin base = 8'h30; alt = 8'h29; end
      8'h16: begin base = 8'h31; alt = 8'h21; end
      8'h1E: begin base = 8'h32; alt = 8'h40; end
      8'h26: begin base = 8'h33; alt = 8'h23; end
      8'h25: begin base = 8'h34; alt = 8'h24; end
      8'h2E: begin base = 8'h35; alt = 8'h25; end
      8'h36: begin base = 8'h36; alt = 8'h5E; end
      8'h3D: begin base = 8'h37; alt = 8'h26; end
      8'h3E: begin base = 8'h38; alt = 8'h2A; end
      8'h46: begin base = 8'h39; alt = 8'h28; end
      c_space: base = 8'h20;
      c_enter: base = 8'h0D;
      default: base = 8'h00;
    endcase
  end

  assign letter = (base >= 8'h61) && (base <= 8'h7A);

  // Letters follow shift^caps; digits follow shift only, as on a US keyboard
  always_comb begin
    if (letter)
      ascii = (shift ^ caps) ? (base - 8'h20) : base;
    else if (shift && (alt != 8'h00))
      ascii = alt;
    else
      ascii = base;
  end

endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_decoder
// Purpose  : Set-2 scan-byte parser producing buffered key events, with
//            shift/caps/held-key tracking, press counting and prefix timeout.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_decoder #(
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_break,
  output logic             evt_ext,
  output logic             evt_repeat,
  output logic [7:0]       evt_ascii,
  output logic             key_down,
  output logic [7:0]       held_code,
  output logic [CNT_W-1:0] key_count,
  output logic             shift_on,
  output logic             caps_on,
  output logic             timeout
);
  import ps2_pkg::*;

  localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;
  logic             evt_valid_q, evt_valid_d;
  logic [7:0]       evt_code_q, evt_code_d;
  logic             evt_break_q, evt_break_d;
  logic             evt_ext_q, evt_ext_d;
  logic             evt_repeat_q, evt_repeat_d;
  logic [7:0]       evt_ascii_q, evt_ascii_d;
  logic             key_down_q, key_down_d;
  logic [7:0]       held_code_q, held_code_d;
  logic             held_ext_q, held_ext_d;
  logic [CNT_W-1:0] key_count_q, key_count_d;
  logic             shift_l_q, shift_l_d;
  logic             shift_r_q, shift_r_d;
  logic             caps_q, caps_d;

  logic       accept;
  logic       emit;
  logic       pfx_ext;
  logic       pfx_brk;
  logic       same_key;
  logic [7:0] map_ascii;

  // The buffer is free when empty or being drained this cycle; nothing is taken in reset
  assign in_ready = !rst && (!evt_valid_q || evt_ready);
  assign accept   = in_valid && in_ready;

  // Prefix flags of the sequence the current byte would complete
  assign pfx_ext  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
  assign pfx_brk  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
  assign same_key = key_down_q && (in_data == held_code_q) && (pfx_ext == held_ext_q);

  scancode_to_ascii u_map (
    .code  (in_data),
    .shift (shift_l_q || shift_r_q),
    .caps  (caps_q),
    .ascii (map_ascii)
  );

  // State, buffer and key-status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tmo_cnt_q    <= '0;
      timeout_q    <= 1'b0;
      evt_valid_q  <= 1'b0;
      evt_code_q   <= 8'h00;
      evt_break_q  <= 1'b0;
      evt_ext_q    <= 1'b0;
      evt_repeat_q <= 1'b0;
      evt_ascii_q  <= 8'h00;
      key_down_q   <= 1'b0;
      held_code_q  <= 8'h00;
      held_ext_q   <= 1'b0;
      key_count_q  <= '0;
      shift_l_q    <= 1'b0;
      shift_r_q    <= 1'b0;
      caps_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_cnt_q    <= tmo_cnt_d;
      timeout_q    <= timeout_d;
      evt_valid_q  <= evt_valid_d;
      evt_code_q   <= evt_code_d;
      evt_break_q  <= evt_break_d;
      evt_ext_q    <= evt_ext_d;
      evt_repeat_q <= evt_repeat_d;
      evt_ascii_q  <= evt_ascii_d;
      key_down_q   <= key_down_d;
      held_code_q  <= held_code_d;
      held_ext_q   <= held_ext_d;
      key_count_q  <= key_count_d;
      shift_l_q    <= shift_l_d;
      shift_r_q    <= shift_r_d;
      caps_q       <= caps_d;
    end
  end

  // Prefix FSM, idle timeout, event buffer load/drain and key-status updates
  always_comb begin
    state_d      = state_q;
    tmo_cnt_d    = tmo_cnt_q;
    timeout_d    = 1'b0;
    evt_valid_d  = evt_valid_q;
    evt_code_d   = evt_code_q;
    evt_break_d  = evt_break_q;
    evt_ext_d    = evt_ext_q;
    evt_repeat_d = evt_repeat_q;
    evt_ascii_d  = evt_ascii_q;
    key_down_d   = key_down_q;
    held_code_d  = held_code_q;
    held_ext_d   = held_ext_q;
    key_count_d  = key_count_q;
    shift_l_d    = shift_l_q;
    shift_r_d    = shift_r_q;
    caps_d       = caps_q;
    emit         = 1'b0;

    if (evt_valid_q && evt_ready) evt_valid_d = 1'b0;

    if (accept) begin
      tmo_cnt_d = '0;
      if (in_data == c_pfx_ext) begin
        state_d = ST_EXT;
      end else if (in_data == c_pfx_brk) begin
        case (state_q)
          ST_IDLE: state_d = ST_BRK;
          ST_EXT:  state_d = ST_EXT_BRK;
          default: state_d = state_q;
        endcase
      end else if (!((state_q == ST_IDLE) && is_discard(in_data))) begin
        emit    = 1'b1;
        state_d = ST_IDLE;
      end
    end else if (state_q != ST_IDLE) begin
      if (tmo_cnt_q == TMO_LAST) begin
        state_d   = ST_IDLE;
        tmo_cnt_d = '0;
        timeout_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end else begin
      tmo_cnt_d = '0;
    end

    if (emit) begin
      evt_valid_d  = 1'b1;
      evt_code_d   = in_data;
      evt_break_d  = pfx_brk;
      evt_ext_d    = pfx_ext;
      evt_repeat_d = !pfx_brk && same_key;
      evt_ascii_d  = (pfx_brk || pfx_ext) ? 8'h00 : map_ascii;
      if (!pfx_brk) begin
        if (!same_key) begin
          key_down_d  = 1'b1;
          held_code_d = in_data;
          held_ext_d  = pfx_ext;
          key_count_d = key_count_q + CNT_W'(1);
          if (!pfx_ext && (in_data == c_caps)) caps_d = !caps_q;
        end
        if (!pfx_ext && (in_data == c_lshift)) shift_l_d = 1'b1;
        if (!pfx_ext && (in_data == c_rshift)) shift_r_d = 1'b1;
      end else begin
        if (same_key) begin
          key_down_d  = 1'b0;
          held_code_d = 8'h00;
          held_ext_d  = 1'b0;
        end
        if (!pfx_ext && (in_data == c_lshift)) shift_l_d = 1'b0;
        if (!pfx_ext && (in_data == c_rshift)) shift_r_d = 1'b0;
      end
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_code   = evt_code_q;
  assign evt_break  = evt_break_q;
  assign evt_ext    = evt_ext_q;
  assign evt_repeat = evt_repeat_q;
  assign evt_ascii  = evt_ascii_q;
  assign key_down   = key_down_q;
  assign held_code  = held_code_q;
  assign key_count  = key_count_q;
  assign shift_on   = shift_l_q || shift_r_q;
  assign caps_on    = caps_q;
  assign timeout    = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_decoder
// Purpose  : Directed, self-checking bench for ps2_key_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;
  localparam int CNT_W = 8;
  localparam int TMO   = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             evt_ready = 1'b1;
  logic             in_ready, evt_valid, evt_break, evt_ext, evt_repeat;
  logic             key_down, shift_on, caps_on, timeout;
  logic [7:0]       evt_code, evt_ascii, held_code;
  logic [CNT_W-1:0] key_count;

  always #5 clk = ~clk;

  ps2_key_decoder #(.CNT_W(CNT_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code), .evt_break(evt_break),
    .evt_ext(evt_ext), .evt_repeat(evt_repeat), .evt_ascii(evt_ascii), .key_down(key_down),
    .held_code(held_code), .key_count(key_count), .shift_on(shift_on), .caps_on(caps_on),
    .timeout(timeout)
  );

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
    logic       rep;
    logic [7:0] ascii;
  } ev_t;

  // Model state: prefix flags rather than an FSM, plus a one-deep event slot
  typedef struct packed {
    logic             ext_seen;
    logic             brk_seen;
    logic [31:0]      idle;
    logic             valid;
    ev_t              ev;
    logic             kd;
    logic [7:0]       held;
    logic             held_ext;
    logic [CNT_W-1:0] cnt;
    logic             sl;
    logic             sr;
    logic             caps;
    logic             tmo;
  } mstate_t;

  mstate_t ms = '0;
  ev_t     log_q[$];
  int      tmo_seen = 0;
  int      n_chk = 0;
  int      n_fail = 0;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46};
  logic [7:0] digit_syms [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26,
    8'h2A, 8'h28};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_ascii(input logic [7:0] c, input logic sh, input logic cp);
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == c) return (sh ^ cp) ? 8'(8'h41 + i) : 8'(8'h61 + i);
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == c) return sh ? digit_syms[i] : 8'(8'h30 + i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  function automatic logic model_discard(input logic [7:0] c);
    return c inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hE1, 8'h00, 8'hFF};
  endfunction

  function automatic mstate_t model_event(input mstate_t s, input logic [7:0] c,
                                          input logic b, input logic x);
    mstate_t n;
    logic    rep;
    n   = s;
    rep = 1'b0;
    n.ev.ascii = (b || x) ? 8'h00 : model_ascii(c, s.sl || s.sr, s.caps);
    if (!b) begin
      rep = s.kd && (c == s.held) && (x == s.held_ext);
      if (!rep) begin
        n.held = c; n.held_ext = x; n.kd = 1'b1;
        n.cnt  = CNT_W'((int'(s.cnt) + 1) % (1 << CNT_W));
        if (!x && c == 8'h58) n.caps = !s.caps;
      end
      if (!x && c == 8'h12) n.sl = 1'b1;
      if (!x && c == 8'h59) n.sr = 1'b1;
    end else begin
      if (s.kd && (c == s.held) && (x == s.held_ext)) begin
        n.kd = 1'b0; n.held = 8'h00; n.held_ext = 1'b0;
      end
      if (!x && c == 8'h12) n.sl = 1'b0;
      if (!x && c == 8'h59) n.sr = 1'b0;
    end
    n.ev.code = c; n.ev.brk = b; n.ev.ext = x; n.ev.rep = rep;
    n.valid = 1'b1;
    return n;
  endfunction

  // Behavioural model advanced on each clock edge
  always @(posedge clk or posedge rst) begin : p_model
    mstate_t n;
    logic    acc;
    if (rst) begin
      ms <= '0;
    end else begin
      n     = ms;
      n.tmo = 1'b0;
      acc   = in_valid && (!ms.valid || evt_ready);
      if (ms.valid && evt_ready) n.valid = 1'b0;
      if (acc) begin
        n.idle = 0;
        if (in_data == 8'hE0) begin
          n.ext_seen = 1'b1; n.brk_seen = 1'b0;
        end else if (in_data == 8'hF0) begin
          n.brk_seen = 1'b1;
        end else if (!(!ms.ext_seen && !ms.brk_seen && model_discard(in_data))) begin
          n = model_event(n, in_data, ms.brk_seen, ms.ext_seen);
          n.ext_seen = 1'b0; n.brk_seen = 1'b0;
        end
      end else if (ms.ext_seen || ms.brk_seen) begin
        n.idle = ms.idle + 1;
        if (n.idle == TMO) begin
          n.ext_seen = 1'b0; n.brk_seen = 1'b0; n.idle = 0; n.tmo = 1'b1;
        end
      end
      ms <= n;
    end
  end

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'(!rst && (!ms.valid || evt_ready)));
    check("evt_valid", 32'(evt_valid), 32'(ms.valid));
    check("key_down", 32'(key_down), 32'(ms.kd));
    check("held_code", 32'(held_code), 32'(ms.held));
    check("key_count", 32'(key_count), 32'(ms.cnt));
    check("shift_on", 32'(shift_on), 32'(ms.sl || ms.sr));
    check("caps_on", 32'(caps_on), 32'(ms.caps));
    check("timeout", 32'(timeout), 32'(ms.tmo));
    if (ms.valid)
      check("event", 32'({evt_code, evt_break, evt_ext, evt_repeat, evt_ascii}), 32'(ms.ev));
  end

  // Log delivered events and timeout pulses for the literal checks
  always @(negedge clk) begin
    if (evt_valid && evt_ready) log_q.push_back({evt_code, evt_break, evt_ext, evt_repeat, evt_ascii});
    if (timeout) tmo_seen <= tmo_seen + 1;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic done;
    done = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = b;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk); done = in_ready;
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    check("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic send_seq(input logic [7:0] b [$]);
    foreach (b[i]) send_byte(b[i]);
    wait_cycles(3);
  endtask

  task automatic chk_ev(input string name, input int back, input ev_t exp);
    if (log_q.size() < back) begin
      n_chk++; n_fail++;
      $display("FAIL %s: only %0d events logged, required at least %0d", name, log_q.size(), back);
    end else begin
      check(name, 32'(log_q[log_q.size() - back]), 32'(exp));
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
  endtask

  initial begin : p_main
    int n0, t0;
    #1 rst = 1'b1;
    wait_cycles(3);
    check("rst_evt_valid", 32'(evt_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_key_count", 32'(key_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // plain make and break
    send_seq('{8'h1C});
    chk_ev("make_1C", 1, {8'h1C, 3'b000, 8'h61});
    check("make_1C_key_down", 32'(key_down), 32'd1);
    check("make_1C_count", 32'(key_count), 32'd1);
    send_seq('{8'hF0, 8'h1C});
    chk_ev("break_1C", 1, {8'h1C, 3'b100, 8'h00});
    check("break_1C_key_down", 32'(key_down), 32'd0);

    // left shift
    send_seq('{8'h12});
    check("lshift_on", 32'(shift_on), 32'd1);
    send_seq('{8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12});
    chk_ev("shift_A", 3, {8'h1C, 3'b000, 8'h41});
    check("shift_off", 32'(shift_on), 32'd0);
    check("shift_count", 32'(key_count), 32'd3);

    // caps lock
    send_seq('{8'h58, 8'hF0, 8'h58, 8'h1C});
    chk_ev("caps_A", 1, {8'h1C, 3'b000, 8'h41});
    check("caps_on", 32'(caps_on), 32'd1);
    check("caps_count", 32'(key_count), 32'd5);
    send_seq('{8'hF0, 8'h1C, 8'h58, 8'hF0, 8'h58});
    check("caps_off", 32'(caps_on), 32'd0);

    // extended make/break
    send_seq('{8'hE0, 8'h75});
    chk_ev("ext_make", 1, {8'h75, 3'b010, 8'h00});
    check("ext_held", 32'(held_code), 32'h75);
    send_seq('{8'hE0, 8'hF0, 8'h75});
    chk_ev("ext_break", 1, {8'h75, 3'b110, 8'h00});
    check("ext_break_key_down", 32'(key_down), 32'd0);

    // discarded status bytes
    n0 = log_q.size();
    send_seq('{8'hFA, 8'hAA});
    check("discard_no_events", 32'(log_q.size()), 32'(n0));

    // typematic repeat
    send_seq('{8'h1C, 8'h1C, 8'h1C});
    chk_ev("rep0", 3, {8'h1C, 3'b000, 8'h61});
    chk_ev("rep1", 2, {8'h1C, 3'b001, 8'h61});
    chk_ev("rep2", 1, {8'h1C, 3'b001, 8'h61});
    check("rep_count", 32'(key_count), 32'd8);
    send_seq('{8'hF0, 8'h1C});

    // right shift on a digit key
    send_seq('{8'h59, 8'h16, 8'hF0, 8'h16, 8'hF0, 8'h59});
    chk_ev("rshift_bang", 3, {8'h16, 3'b000, 8'h21});

    // backpressure: second byte held upstream until the consumer drains
    evt_ready = 1'b0;
    send_byte(8'h32);
    @(posedge clk); #1 in_valid = 1'b1; in_data = 8'h46;
    repeat (4) @(negedge clk);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_held_code", 32'(evt_code), 32'h32);
    @(posedge clk); #1 evt_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_high", 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_cycles(3);
    chk_ev("bp_first", 2, {8'h32, 3'b000, 8'h62});
    chk_ev("bp_second", 1, {8'h46, 3'b000, 8'h39});

    // prefix timeout
    t0 = tmo_seen;
    send_byte(8'hE0);
    wait_cycles(TMO - 2);
    check("tmo_not_early", 32'(tmo_seen - t0), 32'd0);
    wait_cycles(6);
    check("tmo_pulse", 32'(tmo_seen - t0), 32'd1);
    send_seq('{8'h1C});
    chk_ev("after_tmo", 1, {8'h1C, 3'b000, 8'h61});

    // reset discards a buffered event
    evt_ready = 1'b0;
    send_byte(8'h29);
    @(negedge clk);
    check("buffered_valid", 32'(evt_valid), 32'd1);
    do_reset();
    check("rst_drop_valid", 32'(evt_valid), 32'd0);
    evt_ready = 1'b1;

    // reset in the middle of E0 F0
    send_seq('{8'h58, 8'h1C});
    send_byte(8'hE0);
    send_byte(8'hF0);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("mid_rst_outputs", 32'({in_ready, evt_valid, evt_break, evt_ext, evt_repeat, key_down,
                                  shift_on, caps_on, timeout}), 32'd0);
    check("mid_rst_bytes", 32'({evt_code, evt_ascii, held_code, key_count}), 32'd0);
    wait_cycles(2);
    rst = 1'b0;
    send_seq('{8'h1C});
    chk_ev("post_rst_make", 1, {8'h1C, 3'b000, 8'h61});

    // key_count wrap over 256 non-repeat presses from reset
    do_reset();
    for (int i = 0; i < 255; i++) send_byte((i % 2 == 0) ? 8'h1C : 8'h32);
    wait_cycles(2);
    check("count_255", 32'(key_count), 32'd255);
    send_seq('{8'h32});
    check("count_wrap", 32'(key_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : p_watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
